// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the pipeline stall/flush sequencer.
//   - hz_state_t : sequencer state (BOOT, RUN, DRAIN, HALT)
//   - REG_X0     : architectural zero register index, never a hazard source
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Load-use hazard: a load in Execute writes a register that the
    // instruction in Decode reads. Writes to x0 are discarded, so never stall.
    function automatic logic load_use_hazard(input logic       mem_read_e,
                                             input logic [4:0] rd_e,
                                             input logic [4:0] rs1_d,
                                             input logic [4:0] rs2_d);
        return mem_read_e && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk     in  1  clock, rising edge
//     rst     in  1  asynchronous active-high reset, clears the count
//     inc_i   in  1  increment request for this cycle
//     count_o out W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage RV64I pipeline. Drives the PC hold,
//   the FD register hold/clear and the DE register clear. Handles taken
//   redirects, load-use hazards, instruction-memory wait states and halt.
//   Outputs are Mealy: decoded from the registered state and current inputs.
//   Ports:
//     clk, rst               clock (rising edge), async active-high reset
//     Rs1_D, Rs2_D           source register indices in Decode
//     Rd_E, MemRead_E        destination index / load flag in Execute
//     PCSrc_E                taken branch or jump resolved in Execute
//     Imem_valid_F           instruction memory delivers a word this cycle
//     Halt_D                 ecall/ebreak in Decode
//     Stall_F                hold PC
//     Stall_D                hold FD register
//     Flush_D                clear FD register (bubble)
//     Flush_E                clear DE register (bubble)
//     Halted                 core halted
//     Stall_cnt              saturating count of stalled-fetch cycles in RUN/DRAIN
//     Flush_cnt              saturating count of redirects taken
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         Rs1_D,
    input  logic [4:0]         Rs2_D,
    input  logic [4:0]         Rd_E,
    input  logic               MemRead_E,
    input  logic               PCSrc_E,
    input  logic               Imem_valid_F,
    input  logic               Halt_D,
    output logic               Stall_F,
    output logic               Stall_D,
    output logic               Flush_D,
    output logic               Flush_E,
    output logic               Halted,
    output logic [COUNT_W-1:0] Stall_cnt,
    output logic [COUNT_W-1:0] Flush_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;

    logic stall_f;
    logic stall_d_raw;
    logic flush_d;
    logic flush_e;
    logic halted;
    logic redirect_inc;
    logic stall_inc;
    logic lu;

    assign lu = load_use_hazard(MemRead_E, Rd_E, Rs1_D, Rs2_D);

    // While rst is asserted state_q is already BOOT, so the BOOT decode below
    // also covers the reset-held cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        stall_f      = 1'b0;
        stall_d_raw  = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        halted       = 1'b0;
        redirect_inc = 1'b0;

        unique case (state_q)
            BOOT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                state_d = RUN;
            end

            RUN: begin
                if (PCSrc_E) begin
                    // Decode and Execute hold wrong-path work; any same-cycle
                    // halt or load-use belongs to that work and is dropped.
                    flush_d      = 1'b1;
                    flush_e      = 1'b1;
                    redirect_inc = 1'b1;
                    // A fetch still in flight was issued down the old path.
                    state_d      = Imem_valid_F ? RUN : DRAIN;
                end else if (Halt_D) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                    state_d = HALT;
                end else if (lu) begin
                    // One bubble suffices: next cycle the load is in Memory.
                    stall_f     = 1'b1;
                    stall_d_raw = 1'b1;
                    flush_e     = 1'b1;
                end else if (!Imem_valid_F) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end

            DRAIN: begin
                // Hold the redirect target PC and discard the stale word,
                // including on the cycle it finally arrives. Execute holds a
                // bubble here, so PCSrc_E is not examined.
                stall_f = 1'b1;
                flush_d = 1'b1;
                if (Imem_valid_F) begin
                    state_d = RUN;
                end
            end

            HALT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                halted  = 1'b1;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Holding FD while clearing it is contradictory; the clear wins.
    assign Stall_D = stall_d_raw & ~flush_d;
    assign Stall_F = stall_f;
    assign Flush_D = flush_d;
    assign Flush_E = flush_e;
    assign Halted  = halted;

    assign stall_inc = stall_f && ((state_q == RUN) || (state_q == DRAIN));

    sat_counter #(.W(COUNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc),
        .count_o (Stall_cnt)
    );

    sat_counter #(.W(COUNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (redirect_inc),
        .count_o (Flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench. Two instances share all inputs: a 32-bit-counter
//   instance and a 4-bit-counter instance used for saturation. Each cycle the
//   stimulus task computes expected outputs from a behavioural model, queues
//   them, and the sample point (falling edge) pops and compares.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs1_D;
    logic [4:0]  Rs2_D;
    logic [4:0]  Rd_E;
    logic        MemRead_E;
    logic        PCSrc_E;
    logic        Imem_valid_F;
    logic        Halt_D;

    logic        Stall_F, Stall_D, Flush_D, Flush_E, Halted;
    logic [31:0] Stall_cnt, Flush_cnt;

    logic        s_Stall_F, s_Stall_D, s_Flush_D, s_Flush_E, s_Halted;
    logic [3:0]  s_Stall_cnt, s_Flush_cnt;

    pipe_hazard_ctrl #(.COUNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .Rs1_D        (Rs1_D),
        .Rs2_D        (Rs2_D),
        .Rd_E         (Rd_E),
        .MemRead_E    (MemRead_E),
        .PCSrc_E      (PCSrc_E),
        .Imem_valid_F (Imem_valid_F),
        .Halt_D       (Halt_D),
        .Stall_F      (Stall_F),
        .Stall_D      (Stall_D),
        .Flush_D      (Flush_D),
        .Flush_E      (Flush_E),
        .Halted       (Halted),
        .Stall_cnt    (Stall_cnt),
        .Flush_cnt    (Flush_cnt)
    );

    pipe_hazard_ctrl #(.COUNT_W(4)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .Rs1_D        (Rs1_D),
        .Rs2_D        (Rs2_D),
        .Rd_E         (Rd_E),
        .MemRead_E    (MemRead_E),
        .PCSrc_E      (PCSrc_E),
        .Imem_valid_F (Imem_valid_F),
        .Halt_D       (Halt_D),
        .Stall_F      (s_Stall_F),
        .Stall_D      (s_Stall_D),
        .Flush_D      (s_Flush_D),
        .Flush_E      (s_Flush_E),
        .Halted       (s_Halted),
        .Stall_cnt    (s_Stall_cnt),
        .Flush_cnt    (s_Flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  ctl;   // {Stall_F, Stall_D, Flush_D, Flush_E, Halted}
        logic [31:0] sc;
        logic [31:0] fc;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } exp_t;

    exp_t exp_q[$];

    int n_vec;
    int n_miss;

    // Behavioural model state
    hz_state_t   m_state;
    logic [31:0] m_sc, m_fc;
    logic [3:0]  m_sc4, m_fc4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One clock of stimulus. Called just after a rising edge.
    task automatic cyc(input string tag, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic pc, input logic iv, input logic hd);
        exp_t      e;
        hz_state_t nxt;
        logic      sf, sd, fd, fe, hl;
        logic      hazard, s_inc, f_inc;

        rst = r; Rs1_D = rs1; Rs2_D = rs2; Rd_E = rd;
        MemRead_E = mr; PCSrc_E = pc; Imem_valid_F = iv; Halt_D = hd;

        if (r) begin
            m_state = BOOT; m_sc = '0; m_fc = '0; m_sc4 = '0; m_fc4 = '0;
        end

        {sf, sd, fd, fe, hl} = 5'b0;
        f_inc  = 1'b0;
        nxt    = m_state;
        hazard = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

        case (m_state)
            BOOT:  begin sf = 1; fd = 1; fe = 1; nxt = RUN; end
            RUN: begin
                if (pc) begin
                    fd = 1; fe = 1; f_inc = 1;
                    if (!iv) nxt = DRAIN;
                end else if (hd) begin
                    sf = 1; fd = 1; nxt = HALT;
                end else if (hazard) begin
                    sf = 1; sd = 1; fe = 1;
                end else if (!iv) begin
                    sf = 1; fd = 1;
                end
            end
            DRAIN: begin sf = 1; fd = 1; if (iv) nxt = RUN; end
            HALT:  begin sf = 1; fd = 1; hl = 1; end
            default: ;
        endcase
        if (r) nxt = BOOT;
        s_inc = sf && (m_state == RUN || m_state == DRAIN) && !r;

        e.ctl = {sf, sd, fd, fe, hl};
        e.sc  = m_sc;  e.fc  = m_fc;
        e.sc4 = m_sc4; e.fc4 = m_fc4;
        exp_q.push_back(e);

        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".ctl"},   {27'd0, Stall_F, Stall_D, Flush_D, Flush_E, Halted}, {27'd0, e.ctl});
        check({tag, ".sctl"},  {27'd0, s_Stall_F, s_Stall_D, s_Flush_D, s_Flush_E, s_Halted}, {27'd0, e.ctl});
        check({tag, ".scnt"},  Stall_cnt, e.sc);
        check({tag, ".fcnt"},  Flush_cnt, e.fc);
        check({tag, ".scnt4"}, {28'd0, s_Stall_cnt}, {28'd0, e.sc4});
        check({tag, ".fcnt4"}, {28'd0, s_Flush_cnt}, {28'd0, e.fc4});

        @(posedge clk);
        m_state = nxt;
        if (s_inc) begin
            if (m_sc  != 32'hFFFF_FFFF) m_sc  = m_sc + 1;
            if (m_sc4 != 4'hF)          m_sc4 = m_sc4 + 1;
        end
        if (f_inc) begin
            if (m_fc  != 32'hFFFF_FFFF) m_fc  = m_fc + 1;
            if (m_fc4 != 4'hF)          m_fc4 = m_fc4 + 1;
        end
        #1;
    endtask

    // Idle RUN cycle: fetch valid, no hazards.
    task automatic idle(input string tag);
        cyc(tag, 0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        m_state = BOOT; m_sc = '0; m_fc = '0; m_sc4 = '0; m_fc4 = '0;
        rst = 1'b1; Rs1_D = '0; Rs2_D = '0; Rd_E = '0;
        MemRead_E = 0; PCSrc_E = 0; Imem_valid_F = 1; Halt_D = 0;

        @(posedge clk); #1;

        // Reset held 3 cycles, then the single BOOT cycle after release.
        for (int i = 0; i < 3; i++) cyc("rst_hold", 1, 0, 0, 0, 0, 0, 1, 0);
        cyc("boot", 0, 0, 0, 0, 0, 0, 1, 0);
        idle("run0");
        idle("run1");

        // Load-use via rs1, via rs2, and the x0 exemption.
        cyc("lu_rs1", 0, 5'd5, 5'd9, 5'd5, 1, 0, 1, 0);
        idle("lu_after");
        cyc("lu_rs2", 0, 5'd4, 5'd6, 5'd6, 1, 0, 1, 0);
        cyc("lu_x0", 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0);
        cyc("lu_norf", 0, 5'd8, 5'd9, 5'd5, 1, 0, 1, 0);
        cyc("nold", 0, 5'd5, 5'd9, 5'd5, 0, 0, 1, 0);

        // Redirect overriding a same-cycle load-use; stays in RUN.
        cyc("br_lu", 0, 5'd1, 5'd7, 5'd7, 1, 1, 1, 0);
        idle("br_after");

        // Redirect overriding a same-cycle halt.
        cyc("br_halt", 0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1);
        idle("br_halt_after");

        // Imem wait in RUN.
        cyc("imem_wait", 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
        idle("wait_after");

        // Redirect with fetch outstanding: DRAIN for 3 low + 1 valid cycle.
        cyc("br_drain", 0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("drain_wait", 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
        cyc("drain_pc_ignored", 0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1);
        idle("drain_exit");

        // 20 stall cycles: 4-bit counter sticks at 15.
        for (int i = 0; i < 20; i++) cyc("sat", 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
        idle("sat_after");

        // Reset asserted mid-DRAIN returns to BOOT at once.
        cyc("br_drain2", 0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0);
        cyc("drain2", 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
        cyc("rst_drain", 1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
        cyc("boot2", 0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
        idle("run2");
        cyc("lu_cnt", 0, 5'd5, 5'd9, 5'd5, 1, 0, 1, 0);

        // Halt, then ignore redirects, halts, load-use and waits.
        cyc("halt", 0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1);
        cyc("halted_pc", 0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0);
        cyc("halted_lu", 0, 5'd5, 5'd2, 5'd5, 1, 0, 0, 0);
        cyc("halted_pc2", 0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 1);
        idle("halted_idle");

        // Only reset leaves HALT.
        cyc("rst_halt", 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
        cyc("boot3", 0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
        idle("run3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
